timer_alarm_core: RTL and testbench

TIMER_ALARM_CORE -- requirements
Module: timer_alarm_core

---
 rtl/timer_alarm_core_pkg.sv | 39 +++
 rtl/timer_alarm_core.sv | 84 ++++++++
 tb/tb_timer_alarm_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_core_pkg.sv
// Shared definitions for the timer block: register map,
// alarm state encodings and alarm status widths.
package timer_alarm_core_pkg;

  // Register offsets of the timer block as seen by software
  localparam logic [7:0] REG_TIMER_LO   = 8'h00;
  localparam logic [7:0] REG_TIMER_HI   = 8'h04;
  localparam logic [7:0] REG_ALARM_LO   = 8'h08;
  localparam logic [7:0] REG_ALARM_HI   = 8'h0C;
  localparam logic [7:0] REG_PERIOD_LO  = 8'h10;
  localparam logic [7:0] REG_PERIOD_HI  = 8'h14;
  localparam logic [7:0] REG_ALARM_CTRL = 8'h18;
  localparam logic [7:0] REG_ALARM_STAT = 8'h1C;

  // Control register bit positions
  localparam int CTRL_PERIODIC_BIT = 0;
  localparam int CTRL_DISARM_BIT   = 1;
  localparam int CTRL_ACK_BIT      = 2;

  // Alarm state encoding; encoding 3 is unreachable
  localparam int STATE_W  = 2;
  localparam int MISSED_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } alarm_state_e;

  localparam logic [MISSED_W-1:0] MISSED_MAX = '1;

  // Saturating increment for the missed-match counter
  function automatic logic [MISSED_W-1:0] sat_inc(
    input logic [MISSED_W-1:0] v
  );
    return (v == MISSED_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/timer_alarm_core.sv
// 64-bit compare alarm with one-shot and periodic modes,
// level interrupt and a saturating missed-match counter.
module timer_alarm_core
  import timer_alarm_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] TIMER_VALUE,
  input  logic [DATA_W-1:0]   ALARM_DATA,
  input  logic                ALARM_WR_LOW,
  input  logic                ALARM_WR_HIGH,
  input  logic [2*DATA_W-1:0] ALARM_PERIOD,
  input  logic                ALARM_PERIODIC,
  input  logic                ALARM_DISARM,
  input  logic                ALARM_ACK,
  output logic                ALARM_IRQ,
  output logic [STATE_W-1:0]  ALARM_STATE,
  output logic [2*DATA_W-1:0] ALARM_CMP,
  output logic [MISSED_W-1:0] ALARM_MISSED
);

  alarm_state_e        state;
  logic [DATA_W-1:0]   shadow;
  logic [2*DATA_W-1:0] cmp_next;
  logic                armed;
  logic                fired;
  logic                match;
  logic                periodic;

  assign armed    = (state == ST_ARMED);
  assign fired    = (state == ST_FIRED);
  assign match    = armed && (TIMER_VALUE >= ALARM_CMP);
  assign periodic = ALARM_PERIODIC && (|ALARM_PERIOD);
  assign cmp_next = ALARM_CMP + ALARM_PERIOD;

  assign ALARM_STATE = state;

  // Low-half staging register; a disarm in the same cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (ALARM_WR_LOW && !ALARM_DISARM) begin
      shadow <= ALARM_DATA;
    end
  end

  // Alarm FSM with registered irq, compare value and missed count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ALARM_IRQ    <= 1'b0;
      ALARM_CMP    <= '0;
      ALARM_MISSED <= '0;
    end else if (ALARM_DISARM) begin
      state     <= ST_IDLE;
      ALARM_IRQ <= 1'b0;
    end else if (ALARM_WR_HIGH) begin
      state        <= ST_ARMED;
      ALARM_CMP    <= {ALARM_DATA, shadow};
      ALARM_MISSED <= '0;
      if (ALARM_ACK) begin
        ALARM_IRQ <= 1'b0;
      end
    end else if (match) begin
      ALARM_IRQ <= 1'b1;
      if (ALARM_IRQ && !ALARM_ACK) begin
        ALARM_MISSED <= sat_inc(ALARM_MISSED);
      end
      if (periodic) begin
        ALARM_CMP <= cmp_next;
      end else begin
        state <= ST_FIRED;
      end
    end else if (ALARM_ACK) begin
      ALARM_IRQ <= 1'b0;
      if (fired) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm_core.sv
// Scoreboard bench for timer_alarm_core: expected outputs
// are queued with each stimulus cycle and popped after the edge.
module tb_timer_alarm_core;

  localparam int DW = 32;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FIRED = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*DW-1:0] tv = '0;
  logic [DW-1:0] data = '0;
  logic          wr_lo = 1'b0;
  logic          wr_hi = 1'b0;
  logic [2*DW-1:0] period = '0;
  logic          per = 1'b0;
  logic          disarm = 1'b0;
  logic          ack = 1'b0;
  logic          irq;
  logic [1:0]    st;
  logic [2*DW-1:0] cmp;
  logic [7:0]    missed;

  timer_alarm_core #(.DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .TIMER_VALUE    (tv),
    .ALARM_DATA     (data),
    .ALARM_WR_LOW   (wr_lo),
    .ALARM_WR_HIGH  (wr_hi),
    .ALARM_PERIOD   (period),
    .ALARM_PERIODIC (per),
    .ALARM_DISARM   (disarm),
    .ALARM_ACK      (ack),
    .ALARM_IRQ      (irq),
    .ALARM_STATE    (st),
    .ALARM_CMP      (cmp),
    .ALARM_MISSED   (missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        irq;
    logic [1:0]  st;
    logic [63:0] cmp;
    logic [7:0]  missed;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input logic i,
                      input logic [1:0] s, input logic [63:0] c,
                      input logic [7:0] m);
    exp_t e;
    e.tag = tag; e.irq = i; e.st = s; e.cmp = c; e.missed = m;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".irq"}, {63'd0, irq}, {63'd0, e.irq});
      chk({e.tag, ".state"}, {62'd0, st}, {62'd0, e.st});
      chk({e.tag, ".cmp"}, cmp, e.cmp);
      chk({e.tag, ".missed"}, {56'd0, missed}, {56'd0, e.missed});
    end
  endtask

  // One clock: outputs sampled 1ns after the edge, strobes dropped
  task automatic cyc();
    @(posedge clk);
    #1;
    pop_cmp();
    wr_lo = 1'b0; wr_hi = 1'b0; disarm = 1'b0; ack = 1'b0;
  endtask

  initial begin
    int nm;
    logic [7:0] me;
    #2;
    want("reset", 0, S_IDLE, 64'd0, 8'd0);
    pop_cmp();
    @(posedge clk); #1;
    rst = 1'b0;

    // One-shot at 0x100
    wr_lo = 1'b1; data = 32'h100;
    want("os_wrlo", 0, S_IDLE, 64'd0, 8'd0); cyc();
    wr_hi = 1'b1; data = 32'h0;
    want("os_arm", 0, S_ARMED, 64'h100, 8'd0); cyc();
    for (int t = 0; t < 'h100; t++) begin
      tv = 64'(t);
      want("os_wait", 0, S_ARMED, 64'h100, 8'd0); cyc();
    end
    tv = 64'h100;
    want("os_fire", 1, S_FIRED, 64'h100, 8'd0); cyc();
    tv = 64'h101;
    want("os_hold", 1, S_FIRED, 64'h100, 8'd0); cyc();
    ack = 1'b1;
    want("os_ack", 0, S_IDLE, 64'h100, 8'd0); cyc();

    // Periodic 10 + 5k with ack on each irq
    tv = '0; wr_lo = 1'b1; data = 32'd10;
    want("per_wrlo", 0, S_IDLE, 64'h100, 8'd0); cyc();
    wr_hi = 1'b1; data = 32'd0; period = 64'd5; per = 1'b1;
    want("per_arm", 0, S_ARMED, 64'd10, 8'd0); cyc();
    for (int t = 0; t <= 22; t++) begin
      tv = 64'(t);
      ack = (t == 11 || t == 16 || t == 21);
      nm = int'(t >= 10) + int'(t >= 15) + int'(t >= 20);
      want("per_run", (t == 10 || t == 15 || t == 20), S_ARMED,
           64'(10 + 5 * nm), 8'd0);
      cyc();
    end
    disarm = 1'b1;
    want("per_dis", 0, S_IDLE, 64'd25, 8'd0); cyc();

    // Missed counter saturation, period 1, no ack
    tv = 64'd1000000; period = 64'd1; per = 1'b1;
    wr_hi = 1'b1; data = 32'd0;
    want("ms_arm", 0, S_ARMED, 64'd10, 8'd0); cyc();
    for (int n = 1; n <= 300; n++) begin
      me = (n - 1 > 255) ? 8'd255 : 8'(n - 1);
      want("ms_run", 1, S_ARMED, 64'(10 + n), me); cyc();
    end
    ack = 1'b1;
    want("ms_ackhit", 1, S_ARMED, 64'd311, 8'd255); cyc();
    wr_hi = 1'b1; data = 32'd0;
    want("rearm", 1, S_ARMED, 64'd10, 8'd0); cyc();
    ack = 1'b1;
    want("ack_match", 1, S_ARMED, 64'd11, 8'd0); cyc();
    want("miss_one", 1, S_ARMED, 64'd12, 8'd1); cyc();

    // Already-passed compare fires at once
    disarm = 1'b1;
    want("past_dis", 0, S_IDLE, 64'd12, 8'd1); cyc();
    per = 1'b0; tv = 64'd1000; wr_lo = 1'b1; data = 32'd5;
    want("past_wrlo", 0, S_IDLE, 64'd12, 8'd1); cyc();
    wr_hi = 1'b1; data = 32'd0;
    want("past_arm", 0, S_ARMED, 64'd5, 8'd0); cyc();
    want("past_fire", 1, S_FIRED, 64'd5, 8'd0); cyc();
    ack = 1'b1;
    want("past_ack", 0, S_IDLE, 64'd5, 8'd0); cyc();

    // Compare reload wraps modulo 2^64
    tv = '0; per = 1'b1; period = 64'd4;
    wr_lo = 1'b1; data = 32'hFFFF_FFFE;
    want("wrap_wrlo", 0, S_IDLE, 64'd5, 8'd0); cyc();
    wr_hi = 1'b1; data = 32'hFFFF_FFFF;
    want("wrap_arm", 0, S_ARMED, 64'hFFFF_FFFF_FFFF_FFFE, 8'd0); cyc();
    tv = '1;
    want("wrap_fire", 1, S_ARMED, 64'd2, 8'd0); cyc();
    tv = '0; ack = 1'b1;
    want("wrap_ack", 0, S_ARMED, 64'd2, 8'd0); cyc();

    // Disarm beats a same-cycle match
    tv = 64'd5; disarm = 1'b1;
    want("dis_match", 0, S_IDLE, 64'd2, 8'd0); cyc();
    want("dis_stay", 0, S_IDLE, 64'd2, 8'd0); cyc();

    // Async reset while armed
    tv = '0; wr_lo = 1'b1; data = 32'd50;
    want("rst_wrlo", 0, S_IDLE, 64'd2, 8'd0); cyc();
    wr_hi = 1'b1; data = 32'd0;
    want("rst_arm", 0, S_ARMED, 64'd50, 8'd0); cyc();
    tv = 64'd100;
    #2 rst = 1'b1;
    #1;
    want("rst_async", 0, S_IDLE, 64'd0, 8'd0);
    pop_cmp();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want("rst_idle", 0, S_IDLE, 64'd0, 8'd0); cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
